// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit queue.
package uart_pkg;
  localparam int UART_SIZE = 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} txq_state_t;
endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host write port, queue status and TX handshake; UART_TXQ_STATS_EN adds tx_cnt/drop_cnt.
interface uart_tx_queue_if import uart_pkg::*; #(
  parameter int SIZE  = UART_SIZE,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic            wr_en;
  logic [SIZE-1:0] wdata;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic            overflow;
  logic            ovf_clr;
  logic            tx_busy;
  logic            tx_rq;
  logic [SIZE-1:0] txdata;
  logic            drained;
`ifdef UART_TXQ_STATS_EN
  logic [15:0]     tx_cnt;
  logic [15:0]     drop_cnt;
`endif
  modport master (
    output wr_en, wdata, ovf_clr, tx_busy,
    input  full, empty, count, overflow, tx_rq, txdata, drained
`ifdef UART_TXQ_STATS_EN
    , tx_cnt, drop_cnt
`endif
  );
  modport slave (
    input  wr_en, wdata, ovf_clr, tx_busy,
    output full, empty, count, overflow, tx_rq, txdata, drained
`ifdef UART_TXQ_STATS_EN
    , tx_cnt, drop_cnt
`endif
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two byte FIFO with registered count/full/empty.
module uart_sync_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);
  logic [SIZE-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  assign wptr_n = wptr + (AW+1)'(push);
  assign rptr_n = rptr + (AW+1)'(pop);
  assign rdata  = mem[rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
  // The extra pointer MSB tells a full ring from an empty one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      count <= wptr_n - rptr_n;
      empty <= wptr_n == rptr_n;
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
    end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the TX request/busy handshake; UART_TXQ_STATS_EN adds tx_cnt/drop_cnt.
module uart_tx_queue import uart_pkg::*; #(
  parameter int SIZE  = UART_SIZE,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_queue_if.slave q
);
  txq_state_t state, state_n;
  logic busy_m, busy_s, push, pop, rq_n, ovf_evt;
  logic [SIZE-1:0] rdata;
  uart_sync_fifo #(.SIZE(SIZE), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(q.wdata), .rdata(rdata),
    .full(q.full), .empty(q.empty), .count(q.count)
  );
  assign push      = q.wr_en & ~q.full;
  assign ovf_evt   = q.wr_en & q.full;
  assign q.drained = q.empty && state == S_IDLE && !busy_s;
  // tx_busy comes from the TXC domain; only busy_s may steer the FSM.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {busy_s, busy_m} <= 2'b00;
    else {busy_s, busy_m} <= {busy_m, q.tx_busy};
  always_comb begin
    state_n = state;
    rq_n    = q.tx_rq;
    pop     = 1'b0;
    if (state == S_IDLE && !q.empty && !busy_s) begin
      state_n = S_REQ;
      rq_n    = 1'b1;
      pop     = 1'b1;
    end else if (state == S_REQ && busy_s) begin
      state_n = S_WAIT;
      rq_n    = 1'b0;
    end else if (state == S_WAIT && !busy_s) begin
      state_n = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      q.tx_rq    <= 1'b0;
      q.txdata   <= '0;
      q.overflow <= 1'b0;
    end else begin
      state      <= state_n;
      q.tx_rq    <= rq_n;
      if (pop) q.txdata <= rdata;
      q.overflow <= ovf_evt ? 1'b1 : q.ovf_clr ? 1'b0 : q.overflow;
    end
`ifdef UART_TXQ_STATS_EN
  logic handed;
  assign handed = state == S_REQ && busy_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.tx_cnt   <= '0;
      q.drop_cnt <= '0;
    end else begin
      q.tx_cnt   <= q.ovf_clr ? '0 : (handed && q.tx_cnt != 16'hFFFF) ? q.tx_cnt + 16'd1 : q.tx_cnt;
      q.drop_cnt <= q.ovf_clr ? '0 : (ovf_evt && q.drop_cnt != 16'hFFFF) ? q.drop_cnt + 16'd1 : q.drop_cnt;
    end
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed checks of uart_tx_queue against a behavioural TX model.
module tb_uart_tx_queue;
  localparam int FRAME = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic hold_busy = 1'b0, model_busy = 1'b0, tx_auto = 1'b1;
  logic bs1 = 1'b0, bs2 = 1'b0, bs2_prev = 1'b0, rq_prev = 1'b0;
  int checks = 0, errors = 0;
  int peak;
  logic [7:0] rx_q[$], exp_q[$];
  always #5 clk = ~clk;
  uart_tx_queue_if #(.SIZE(8), .DEPTH(16)) q();
  uart_tx_queue #(.SIZE(8), .DEPTH(16)) dut(.clk(clk), .rst_n(rst_n), .q(q));
  assign q.tx_busy = hold_busy | model_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    q.wr_en = 1'b1;
    q.wdata = b;
    exp_q.push_back(b);
    @(negedge clk);
    q.wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (n < 3000 && !(q.drained && rx_q.size() == exp_q.size())) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rx_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    chk({tag, "_drained"}, 32'(q.drained), 32'd1);
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    rx_q.delete();
    exp_q.delete();
  endtask

  // TX stand-in: answers a request with busy after two cycles and keeps it for one frame.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (tx_auto && q.tx_rq && !model_busy) begin
        d = q.txdata;
        repeat (2) @(negedge clk);
        chk("txdata_stable", 32'(q.txdata), 32'(d));
        rx_q.push_back(d);
        model_busy = 1'b1;
        repeat (FRAME) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bs1 <= 1'b0;
      bs2 <= 1'b0;
    end else begin
      bs1 <= q.tx_busy;
      bs2 <= bs1;
    end

  always @(negedge clk) begin
    if (q.tx_rq && !rq_prev) chk("rq_rise_while_busy", 32'(bs2_prev), 32'd0);
    rq_prev  <= q.tx_rq;
    bs2_prev <= bs2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    q.wr_en = 1'b0;
    q.wdata = '0;
    q.ovf_clr = 1'b0;
    #12;
    chk("rst_count", 32'(q.count), 32'd0);
    chk("rst_empty", 32'(q.empty), 32'd1);
    chk("rst_full", 32'(q.full), 32'd0);
    chk("rst_overflow", 32'(q.overflow), 32'd0);
    chk("rst_tx_rq", 32'(q.tx_rq), 32'd0);
    chk("rst_txdata", 32'(q.txdata), 32'd0);
    chk("rst_drained", 32'(q.drained), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // single byte
    wr(8'hA5);
    chk("single_count", 32'(q.count), 32'd1);
    chk("single_empty", 32'(q.empty), 32'd0);
    chk("single_rq_early", 32'(q.tx_rq), 32'd0);
    @(negedge clk);
    chk("single_rq", 32'(q.tx_rq), 32'd1);
    chk("single_txdata", 32'(q.txdata), 32'hA5);
    chk("single_count_pop", 32'(q.count), 32'd0);
    drain("single");
    // burst of four
    peak = 0;
    for (int i = 1; i <= 4; i++) begin
      wr(8'(i));
      if (int'(q.count) > peak) peak = int'(q.count);
    end
    chk("burst_peak", 32'(peak), 32'd3);
    drain("burst");
    // fill to full and overflow
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    chk("fill_full", 32'(q.full), 32'd1);
    chk("fill_count", 32'(q.count), 32'd16);
    chk("fill_no_ovf", 32'(q.overflow), 32'd0);
    q.wr_en = 1'b1;
    q.wdata = 8'hEE;
    @(negedge clk);
    q.wr_en = 1'b0;
    chk("ovf_set", 32'(q.overflow), 32'd1);
    chk("ovf_count", 32'(q.count), 32'd16);
    chk("ovf_full", 32'(q.full), 32'd1);
`ifdef UART_TXQ_STATS_EN
    chk("ovf_drop_cnt", 32'(q.drop_cnt), 32'd1);
    chk("ovf_tx_cnt", 32'(q.tx_cnt), 32'd5);
`endif
    q.ovf_clr = 1'b1;
    @(negedge clk);
    q.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(q.overflow), 32'd0);
`ifdef UART_TXQ_STATS_EN
    chk("clr_drop_cnt", 32'(q.drop_cnt), 32'd0);
    chk("clr_tx_cnt", 32'(q.tx_cnt), 32'd0);
`endif
    hold_busy = 1'b0;
    drain("full");
`ifdef UART_TXQ_STATS_EN
    chk("full_tx_cnt", 32'(q.tx_cnt), 32'd16);
`endif
    // write and pop on the same edge with five queued
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) wr(8'(8'h30 + i));
    chk("wp_count_before", 32'(q.count), 32'd5);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    wr(8'h35);
    chk("wp_count_after", 32'(q.count), 32'd5);
    chk("wp_rq", 32'(q.tx_rq), 32'd1);
    chk("wp_txdata", 32'(q.txdata), 32'h30);
    drain("wr_pop");
    // asynchronous reset while a request is pending
    tx_auto = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(8'h50 + i));
    repeat (3) @(negedge clk);
    chk("mid_rq", 32'(q.tx_rq), 32'd1);
    chk("mid_count", 32'(q.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rq", 32'(q.tx_rq), 32'd0);
    chk("arst_count", 32'(q.count), 32'd0);
    chk("arst_empty", 32'(q.empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    tx_auto = 1'b1;
    @(negedge clk);
    chk("arst_idle_rq", 32'(q.tx_rq), 32'd0);
    // stream 40 bytes with random gaps, honouring full
    for (int i = 0; i < 40; i++) begin
      int w = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      while (q.full && w < 500) begin
        @(negedge clk);
        w++;
      end
      wr(8'(8'h40 + i));
    end
    drain("wrap");
    chk("wrap_no_ovf", 32'(q.overflow), 32'd0);
`ifdef UART_TXQ_STATS_EN
    chk("wrap_tx_cnt", 32'(q.tx_cnt), 32'd40);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue and request sequencer sitting directly upstream of the TX serializer.
- Accepts bytes from a host-side write strobe into a power-of-two FIFO, then drives the TX handshake one byte at a time: TXDATA, TX_RQ, wait for TX_BUSY to rise, wait for TX_BUSY to fall.
- Lets software or a test source burst bytes without tracking baud timing.

Parameters:
- SIZE, 8, data width in bits; must match TX SIZE.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
- CLK  in  1  system clock; same clock that drives the baud generator.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  write strobe; one byte per cycle while high.
- WDATA  in  SIZE  byte to enqueue.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky flag: a write was attempted while FULL.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.
- TX_BUSY  in  1  busy flag from TX; asynchronous to CLK (TX runs on TXC), so it is synchronized internally.
- TX_RQ  out  1  transmit request to TX.
- TXDATA  out  SIZE  byte presented to TX; stable whenever TX_RQ is high.
- DRAINED  out  1  FIFO empty, FSM in S_IDLE and synchronized busy low.

Behaviour:
- Reset values:
  - FIFO pointers 0; COUNT 0; EMPTY 1; FULL 0; OVERFLOW 0.
  - TX_RQ 0; TXDATA 0; DRAINED 1; FSM in S_IDLE; synchronizer flops 0.
  - Reset mid-frame drops all queued bytes and deasserts TX_RQ immediately (asynchronous). TX is not reset by this block.
- TX_BUSY synchronization:
  - 2-flop synchronizer produces busy_s.
  - All FSM decisions use busy_s only.
- Write:
  - Accepted on a CLK edge when WR_EN=1 and FULL=0 (FULL as registered before the edge).
  - Accepted write: mem[wptr]<=WDATA, wptr increments with wrap modulo DEPTH (extra MSB for full/empty).
  - WR_EN=1 while FULL=1: data dropped, pointers unchanged, OVERFLOW<=1.
  - A pop in the same cycle does not rescue a write attempted while FULL.
- Overflow clear:
  - OVF_CLR=1 clears OVERFLOW.
  - Simultaneous overflow event and OVF_CLR: set wins.
- FSM states:
  - S_IDLE: if EMPTY=0 and busy_s=0, then TXDATA<=mem[rptr], rptr++, TX_RQ<=1, go to S_REQ.
  - S_REQ: hold TX_RQ and TXDATA. When busy_s=1, TX_RQ<=0 and go to S_WAIT.
  - S_WAIT: when busy_s=0, go to S_IDLE.
- Latency:
  - Write on edge n into an empty, idle queue gives TX_RQ high after edge n+1.
  - Back-to-back bytes: the next pop occurs one cycle after the S_WAIT to S_IDLE transition.
- Simultaneous write and pop: COUNT unchanged. A pop in the same cycle as a write to an empty FIFO is impossible, because the pop uses the registered EMPTY.
- COUNT, FULL, EMPTY: registered; update on the same edge as the pointer change.
- DRAINED: combinational from EMPTY, state and busy_s.

Optional Feature:
- UART_TXQ_STATS_EN defined:
  - Adds output TX_CNT[15:0]: counts bytes handed to TX (S_REQ to S_WAIT transitions).
  - Adds output DROP_CNT[15:0]: counts rejected writes.
  - Both saturate at 16'hFFFF, reset to 0, and clear on OVF_CLR.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} txq_state_t.
  - localparam UART_SIZE=8.
- Sub-module uart_sync_fifo (storage, pointers, COUNT/FULL/EMPTY).
- Top-level uart_tx_queue holds the synchronizer, FSM and overflow/stats logic.

Test Plan:
- Reset, then write 8'hA5 with TX and baud generator attached (FREQ_DIV_FACT=10):
  - TX_RQ rises one cycle after the write.
  - TXDATA=8'hA5 while TX_RQ is high.
  - RX receives 8'hA5.
  - DRAINED returns to 1.
- Burst-write 8'h01..8'h04 on consecutive cycles:
  - COUNT peaks at 3 or 4.
  - RX receives 01, 02, 03, 04 in order.
  - TX_RQ never rises while busy_s=1.
- Hold TX_BUSY high and write 17 bytes with DEPTH=16:
  - FULL=1 after byte 16; OVERFLOW=1; COUNT=16.
  - With the macro: DROP_CNT=1. OVF_CLR clears both.
- Write and pop in the same cycle with COUNT=5: COUNT stays 5 and wptr/rptr both advance.
- Assert RST_N=0 while in S_REQ with 3 bytes queued: TX_RQ=0, COUNT=0, EMPTY=1 immediately, with no pending edge needed.
- Pointer wrap: 40 bytes streamed through DEPTH=16 with random write gaps: all bytes received in order and no OVERFLOW.
